// File: rtl/iris_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// iris_mem_arbiter_if : requester ports plus AXI-Lite master bundle
// Rev 1.0
// ============================================================================
interface iris_mem_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]          req_wstrb;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic [1:0]                    rsp_resp;

    logic                          m_awvalid;
    logic                          m_awready;
    logic [ADDR_WIDTH-1:0]         m_awaddr;
    logic                          m_wvalid;
    logic                          m_wready;
    logic [DATA_WIDTH-1:0]         m_wdata;
    logic [3:0]                    m_wstrb;
    logic                          m_bvalid;
    logic                          m_bready;
    logic [1:0]                    m_bresp;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [ADDR_WIDTH-1:0]         m_araddr;
    logic                          m_rvalid;
    logic                          m_rready;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic [1:0]                    m_rresp;

    // Arbiter side: accepts requester commands, drives the memory slave
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp,
        output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
        output m_arvalid, m_araddr, m_rready,
        input  m_awready, m_wready, m_bvalid, m_bresp,
        input  m_arready, m_rvalid, m_rdata, m_rresp
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
        input  m_arvalid, m_araddr, m_rready,
        output m_awready, m_wready, m_bvalid, m_bresp,
        output m_arready, m_rvalid, m_rdata, m_rresp
    );
endinterface
`default_nettype wire

// File: rtl/iris_mem_arbiter.sv
`default_nettype none
// ============================================================================
// iris_mem_arbiter : round-robin arbiter, NUM_REQ requesters -> one AXI-Lite slave
// Rev 1.0
// ============================================================================
module iris_mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24
) (
    input  wire logic           clk,
    input  wire logic           rst,
    iris_mem_arbiter_if.master  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_RR   = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    logic [2:0]            state_q,   state_d;
    logic [PW-1:0]         last_q,    last_d;
    logic [PW-1:0]         port_q,    port_d;
    logic                  we_q,      we_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [3:0]            wstrb_q,   wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q,  w_done_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            resp_q,    resp_d;

    logic                  w_found;
    logic [PW-1:0]         w_gidx;
    logic [PW-1:0]         w_cand;
    int                    w_idx;

    // Search starts one past the last served port so every requester gets a turn
    always_comb begin : arb_search
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        w_idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = int'(last_q) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_cand = PW'(w_idx);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= PW'(NUM_REQ - 1);
            port_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            port_q    <= port_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        last_d    = last_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    port_d    = w_gidx;
                    we_d      = bus.req_we[w_gidx];
                    addr_d    = bus.req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d   = bus.req_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d   = bus.req_wstrb[w_gidx*4 +: 4];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.req_we[w_gidx] ? S_WR : S_RD;
                end
            end
            S_WR: begin
                // AW and W complete independently; B is awaited only once both are in
                aw_done_d = aw_done_q | bus.m_awready;
                w_done_d  = w_done_q  | bus.m_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (bus.m_bvalid) begin
                    resp_d  = bus.m_bresp;
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RD: begin
                if (bus.m_arready) begin
                    state_d = S_RR;
                end
            end
            S_RR: begin
                if (bus.m_rvalid) begin
                    rdata_d = bus.m_rdata;
                    resp_d  = bus.m_rresp;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                last_d  = port_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin : outputs
        bus.req_ready = (state_q == S_IDLE && w_found) ? (NUM_REQ'(1) << w_gidx) : '0;
        bus.rsp_valid = (state_q == S_RSP) ? (NUM_REQ'(1) << port_q) : '0;
        bus.rsp_rdata = rdata_q;
        bus.rsp_resp  = resp_q;
        bus.m_awvalid = (state_q == S_WR) && !aw_done_q;
        bus.m_awaddr  = addr_q;
        bus.m_wvalid  = (state_q == S_WR) && !w_done_q;
        bus.m_wdata   = wdata_q;
        bus.m_wstrb   = wstrb_q;
        bus.m_bready  = (state_q == S_WB);
        bus.m_arvalid = (state_q == S_RD);
        bus.m_araddr  = addr_q;
        bus.m_rready  = (state_q == S_RR);
    end
endmodule
`default_nettype wire

// File: tb/tb_iris_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_iris_mem_arbiter : vector table + scoreboard bench with an AXI-Lite slave model
// Rev 1.0
// ============================================================================
module tb_iris_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iris_mem_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(24)) bus ();

    iris_mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- slave model ----------------
    logic [23:0] mem [0:255];
    bit          preloaded = 0;
    int          aw_stall  = 0;
    int          r_stall   = 0;
    logic [1:0]  s_err     = 2'd0;
    int          aw_wait, r_cnt;
    bit          have_aw, have_w, r_pend;
    logic [15:0] s_awaddr;
    logic [23:0] s_wdata, s_word;
    logic [3:0]  s_wstrb;

    assign bus.m_awready = (aw_wait >= aw_stall);
    assign bus.m_wready  = 1'b1;
    assign bus.m_arready = 1'b1;
    assign bus.m_bresp   = s_err;
    assign bus.m_rresp   = s_err;

    always @(posedge clk) begin
        if (rst) begin
            if (!preloaded) begin
                for (int a = 0; a < 256; a++) mem[a] <= '0;
                mem[8'h10] <= 24'hABCDEF;
                preloaded  <= 1;
            end
            aw_wait <= 0; have_aw <= 0; have_w <= 0; r_pend <= 0; r_cnt <= 0;
            bus.m_bvalid <= 0; bus.m_rvalid <= 0; bus.m_rdata <= '0;
        end else begin
            if (bus.m_awvalid && !bus.m_awready) aw_wait <= aw_wait + 1;
            if (bus.m_awvalid && bus.m_awready) begin
                aw_wait <= 0; have_aw <= 1; s_awaddr <= bus.m_awaddr;
            end
            if (bus.m_wvalid && bus.m_wready) begin
                have_w <= 1; s_wdata <= bus.m_wdata; s_wstrb <= bus.m_wstrb;
            end
            if (have_aw && have_w && !bus.m_bvalid) begin
                s_word = mem[s_awaddr[7:0]];
                for (int b = 0; b < 3; b++)
                    if (s_wstrb[b]) s_word[b*8 +: 8] = s_wdata[b*8 +: 8];
                mem[s_awaddr[7:0]] <= s_word;
                bus.m_bvalid <= 1; have_aw <= 0; have_w <= 0;
            end
            if (bus.m_bvalid && bus.m_bready) bus.m_bvalid <= 0;
            if (bus.m_arvalid && bus.m_arready) begin
                bus.m_rdata <= mem[bus.m_araddr[7:0]];
                if (r_stall == 0) bus.m_rvalid <= 1;
                else begin r_pend <= 1; r_cnt <= 1; end
            end
            if (r_pend) begin
                if (r_cnt >= r_stall) begin bus.m_rvalid <= 1; r_pend <= 0; end
                else r_cnt <= r_cnt + 1;
            end
            if (bus.m_rvalid && bus.m_rready) bus.m_rvalid <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          port;
        logic [23:0] rdata;
        logic [1:0]  resp;
        int          lat;
        int          gcyc;
    } sb_t;
    sb_t sb[$];
    sb_t mon_it;

    typedef struct {
        int          port;
        bit          we;
        logic [15:0] addr;
        logic [23:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  err;
        logic [23:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b expected none (cycle %0d)",
                         bus.rsp_valid, cyc);
            end else begin
                mon_it = sb.pop_front();
                chk("rsp_valid", {30'd0, bus.rsp_valid}, 32'(2'b01 << mon_it.port));
                chk("rsp_rdata", {8'd0, bus.rsp_rdata}, {8'd0, mon_it.rdata});
                chk("rsp_resp",  {30'd0, bus.rsp_resp}, {30'd0, mon_it.resp});
                if (mon_it.lat != 0) chk("rsp_latency", 32'(cyc - mon_it.gcyc), 32'(mon_it.lat));
            end
        end
    end

    // write-channel observer for the stalled-AW sequence
    bit watch = 0;
    int av_cnt, wv_cnt, addr_bad, early_b;
    always @(negedge clk) begin
        if (!watch) begin
            av_cnt = 0; wv_cnt = 0; addr_bad = 0; early_b = 0;
        end else begin
            if (bus.m_awvalid) av_cnt++;
            if (bus.m_awvalid && bus.m_awaddr !== 16'h0040) addr_bad++;
            if (bus.m_wvalid) wv_cnt++;
            if (bus.m_wvalid && bus.m_wdata !== 24'h0A0B0C) addr_bad++;
            if (bus.m_bready && (bus.m_awvalid || bus.m_wvalid)) early_b++;
        end
    end

    // Called right after a negedge with request inputs already driven
    task automatic grant_and_push(input logic [1:0] exp_ready, input sb_t item);
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                chk("grant", {30'd0, bus.req_ready}, {30'd0, exp_ready});
                chk("grant_serial", 32'(sb.size()), 32'd0);
                item.gcyc = cyc;
                sb.push_back(item);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got no req_ready expected 0x%0h", exp_ready);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && sb.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic drive_port(input int p, input bit we, input logic [15:0] a,
                              input logic [23:0] d, input logic [3:0] s);
        bus.req_valid[p]        = 1'b1;
        bus.req_we[p]           = we;
        bus.req_addr[p*16 +: 16] = a;
        bus.req_wdata[p*24 +: 24] = d;
        bus.req_wstrb[p*4 +: 4]  = s;
    endtask

    sb_t it;

    initial begin
        vecs[0] = '{0, 0, 16'h0010, 24'h0,      4'h0, 2'd0, 24'hABCDEF, 2'd0, 3};
        vecs[1] = '{1, 1, 16'h0020, 24'h123456, 4'h7, 2'd0, 24'h000000, 2'd0, 4};
        vecs[2] = '{1, 1, 16'h0020, 24'hFFFFAA, 4'h1, 2'd0, 24'h000000, 2'd0, 4};
        vecs[3] = '{1, 0, 16'h0020, 24'h0,      4'h0, 2'd0, 24'h1234AA, 2'd0, 3};
        vecs[4] = '{1, 0, 16'hFFFF, 24'h0,      4'h0, 2'd0, 24'h000000, 2'd0, 3};
        vecs[5] = '{0, 1, 16'h0030, 24'h555555, 4'hF, 2'd2, 24'h000000, 2'd2, 4};
        vecs[6] = '{0, 0, 16'h0030, 24'h0,      4'h0, 2'd3, 24'h555555, 2'd3, 3};

        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {8'd0, bus.rsp_rdata}, 32'd0);
        chk("rst_rsp_resp",  {30'd0, bus.rsp_resp}, 32'd0);
        chk("rst_valids", {27'd0, bus.m_awvalid, bus.m_wvalid, bus.m_bready,
                           bus.m_arvalid, bus.m_rready}, 32'd0);
        rst = 1'b0;

        // table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            s_err = vecs[i].err;
            drive_port(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            it = '{vecs[i].port, vecs[i].exp_rdata, vecs[i].exp_resp, vecs[i].exp_lat, 0};
            grant_and_push(2'b01 << vecs[i].port, it);
            @(posedge clk); #1;
            bus.req_valid = '0;
            wait_drain();
        end
        s_err = 2'd0;
        repeat (3) @(negedge clk);
        chk("hold_rdata", {8'd0, bus.rsp_rdata}, 32'h555555);
        chk("hold_resp",  {30'd0, bus.rsp_resp}, 32'd3);

        // both ports requesting continuously from reset: strict alternation
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_port(0, 0, 16'h0010, 24'h0, 4'h0);
        drive_port(1, 0, 16'h0020, 24'h0, 4'h0);
        for (int t = 0; t < 6; t++) begin
            it = '{t % 2, (t % 2) ? 24'h1234AA : 24'hABCDEF, 2'd0, 3, 0};
            grant_and_push((t % 2) ? 2'b10 : 2'b01, it);
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = '0;
        wait_drain();

        // AW held off 5 cycles while W is accepted at once
        aw_stall = 5;
        @(negedge clk);
        watch = 1;
        drive_port(0, 1, 16'h0040, 24'h0A0B0C, 4'hF);
        it = '{0, 24'h0, 2'd0, 9, 0};
        grant_and_push(2'b01, it);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain();
        chk("stall_awvalid_cycles", 32'(av_cnt), 32'd6);
        chk("stall_wvalid_cycles",  32'(wv_cnt), 32'd1);
        chk("stall_addr_data_stable", 32'(addr_bad), 32'd0);
        chk("stall_bready_early", 32'(early_b), 32'd0);
        watch = 0;
        aw_stall = 0;

        // reset while waiting on R, then port 0 served first
        r_stall = 4;
        @(negedge clk);
        drive_port(0, 0, 16'h0010, 24'h0, 4'h0);
        it = '{0, 24'hABCDEF, 2'd0, 0, 0};
        grant_and_push(2'b01, it);
        @(posedge clk); #1;
        bus.req_valid = '0;
        begin
            bit seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                seen = bus.m_rready;
            end
            chk("mid_rst_in_rr", {31'd0, seen}, 32'd1);
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("mid_rst_valids", {26'd0, bus.m_awvalid, bus.m_wvalid, bus.m_bready,
                               bus.m_arvalid, bus.m_rready, bus.m_rvalid}, 32'd0);
        chk("mid_rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_rsp_rdata", {8'd0, bus.rsp_rdata}, 32'd0);
        chk("mid_rst_rsp_resp",  {30'd0, bus.rsp_resp}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        r_stall = 0;
        repeat (6) @(negedge clk);
        drive_port(0, 0, 16'h0010, 24'h0, 4'h0);
        drive_port(1, 0, 16'h0020, 24'h0, 4'h0);
        it = '{0, 24'hABCDEF, 2'd0, 3, 0};
        grant_and_push(2'b01, it);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
